// File: rtl/mips_test_pkg.sv
// Shared types and constants for the data-memory write monitor.
// Optional build macro used by the monitor: MEM_MONITOR_LOG_EN.
package mips_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PASS    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_t;

  // One log entry is {dataadr, writedata}
  localparam int LOG_W = 64;

  // Saturation ceiling for the 16-bit store counters
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mon_log_fifo.sv
// Small synchronous FIFO holding mismatched stores.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and the caller decides what to flag.
// Built only when MEM_MONITOR_LOG_EN is defined.
module mon_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_C);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head entry; forced to zero while empty so stale data never shows
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers (wrap naturally at the power-of-two depth) and occupancy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Bus-side monitor on the processor data-memory write port. Armed with an
// expected (address, data) store and a cycle budget; reports pass/timeout,
// store counts and elapsed cycles.
// Define MEM_MONITOR_LOG_EN to build the mismatch log FIFO and overflow flag;
// without it the log outputs are tied low and i_log_pop is ignored.
module mem_write_monitor
  import mips_test_pkg::*;
#(
  parameter int TIMEOUT   = 100,
  parameter int LOG_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_expadr,
  input  logic [31:0] i_expdata,
  input  logic        i_memwrite,
  input  logic [31:0] i_dataadr,
  input  logic [31:0] i_writedata,
  input  logic        i_log_pop,
  output logic        o_done,
  output logic        o_pass,
  output logic [31:0] o_cycles,
  output logic [15:0] o_wrcount,
  output logic [15:0] o_miscount,
  output logic        o_log_valid,
  output logic [31:0] o_log_adr,
  output logic [31:0] o_log_data,
  output logic        o_log_overflow
);

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

  mon_state_t  r_state;
  logic [31:0] r_expadr;
  logic [31:0] r_expdata;
  logic [31:0] r_cycles;
  logic [15:0] r_wrcount;
  logic [15:0] r_miscount;
  logic        r_done;
  logic        r_pass;

  logic        w_match;
  logic        w_mismatch_store;
  logic [31:0] w_cycles_nxt;

  assign w_match          = (i_dataadr == r_expadr) && (i_writedata == r_expdata);
  assign w_mismatch_store = (r_state == ST_ARMED) && !i_start && i_memwrite && !w_match;
  assign w_cycles_nxt     = r_cycles + 32'd1;

  // Run controller: start re-arms from any state and overrides this cycle's store
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_expadr   <= '0;
      r_expdata  <= '0;
      r_cycles   <= '0;
      r_wrcount  <= '0;
      r_miscount <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else if (i_start) begin
      r_state    <= ST_ARMED;
      r_expadr   <= i_expadr;
      r_expdata  <= i_expdata;
      r_cycles   <= '0;
      r_wrcount  <= '0;
      r_miscount <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          r_cycles <= w_cycles_nxt;
          if (i_memwrite) begin
            r_wrcount <= sat_inc16(r_wrcount);
            if (!w_match) r_miscount <= sat_inc16(r_miscount);
          end
          // A match on the budget's last edge still counts as a pass
          if (i_memwrite && w_match) begin
            r_state <= ST_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_cycles_nxt >= TIMEOUT_C) begin
            r_state <= ST_TIMEOUT;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_cycles   = r_cycles;
  assign o_wrcount  = r_wrcount;
  assign o_miscount = r_miscount;

`ifdef MEM_MONITOR_LOG_EN
  logic             w_log_full;
  logic             w_log_empty;
  logic [LOG_W-1:0] w_log_head;
  logic             r_log_overflow;

  mon_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LOG_W)
  ) u_log (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_start),
    .i_push  (w_mismatch_store),
    .i_pop   (i_log_pop),
    .i_data  ({i_dataadr, i_writedata}),
    .o_data  (w_log_head),
    .o_full  (w_log_full),
    .o_empty (w_log_empty)
  );

  // Sticky drop flag: a pop in the same cycle makes room, so nothing is lost then
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_log_overflow <= 1'b0;
    end else if (i_start) begin
      r_log_overflow <= 1'b0;
    end else if (w_mismatch_store && w_log_full && !i_log_pop) begin
      r_log_overflow <= 1'b1;
    end
  end

  assign o_log_valid    = !w_log_empty;
  assign o_log_adr      = w_log_head[63:32];
  assign o_log_data     = w_log_head[31:0];
  assign o_log_overflow = r_log_overflow;
`else
  logic w_unused_log;

  assign w_unused_log   = i_log_pop | w_mismatch_store | (LOG_DEPTH == 0);
  assign o_log_valid    = 1'b0;
  assign o_log_adr      = '0;
  assign o_log_data     = '0;
  assign o_log_overflow = 1'b0;
`endif

endmodule
